// File: rtl/tube_scan_display.sv
// Latches DIGITS priority-encoded request channels and time-multiplexes them onto common-anode tubes.
// Optional macro TUBE_SCAN_GHOST_BLANK_EN inserts one dark cycle at the end of every digit slot.
module tube_scan_display #(
    parameter  int DIGITS = 4,
    parameter  int IN_W   = 8,
    parameter  int DIV    = 50000,
    localparam int CODE_W = $clog2(IN_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DIGITS*IN_W-1:0]   x,
    input  logic                     load,
    output logic [DIGITS*CODE_W-1:0] code,
    output logic [DIGITS-1:0]        valid,
    output logic [6:0]               seg,
    output logic [DIGITS-1:0]        an
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(DIV);

    logic [DIGITS-1:0][CODE_W-1:0] enc_code, code_q;
    logic [DIGITS-1:0]             enc_any, valid_q;
    logic [CNT_W-1:0]              cnt;
    logic [IDX_W-1:0]              idx;
    logic                          cnt_last, idx_last;
    logic [DIGITS-1:0]             an_nxt;
    logic [6:0]                    seg_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    // Per-channel priority encoder: later (higher) set bits override lower ones.
    for (genvar k = 0; k < DIGITS; k++) begin : g_lane
        logic [CODE_W-1:0] lane_code;
        always_comb begin
            lane_code = '0;
            for (int i = 0; i < IN_W; i++)
                if (x[k*IN_W+i]) lane_code = CODE_W'(i);
        end
        assign enc_code[k] = lane_code;
        assign enc_any[k]  = |x[k*IN_W +: IN_W];
    end

    assign cnt_last = (cnt == CNT_W'(DIV - 1));
    assign idx_last = (idx == IDX_W'(DIGITS - 1));

    always_comb begin
        an_nxt  = ~(DIGITS'(1) << idx);
`ifdef TUBE_SCAN_GHOST_BLANK_EN
        if (cnt_last) an_nxt = '1;
`endif
        seg_nxt = valid_q[idx] ? glyph(4'(code_q[idx])) : 7'b1111111;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            code_q  <= '0;
            valid_q <= '0;
            an      <= '1;
            seg     <= 7'b1111111;
        end else begin
            if (load) begin
                code_q  <= enc_code;
                valid_q <= enc_any;
            end
            if (cnt_last) begin
                cnt <= '0;
                idx <= idx_last ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_tube_scan_display.sv
// Directed bench for tube_scan_display (DIGITS=4, IN_W=8, DIV=4); honours TUBE_SCAN_GHOST_BLANK_EN.
module tb_tube_scan_display;
    localparam int DIGITS = 4;
    localparam int IN_W   = 8;
    localparam int DIV    = 4;
    localparam int CODE_W = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [31:0] x = '0;
    logic [11:0] code;
    logic [3:0]  valid;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int failures = 0;

    tube_scan_display #(.DIGITS(DIGITS), .IN_W(IN_W), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .load(load),
        .code(code), .valid(valid), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [11:0] code;
        logic [3:0]  valid;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            default: return 7'b0001111;
        endcase
    endfunction

    // Expected an after edge n (n=1 is the first edge after reset release).
    function automatic logic [3:0] exp_an(input int n);
        int pos;
        int d;
        logic [3:0] one;
        pos = (n - 1) % DIV;
        d   = ((n - 1) / DIV) % DIGITS;
        one = 4'b0001;
`ifdef TUBE_SCAN_GHOST_BLANK_EN
        if (pos == DIV - 1) return 4'b1111;
`endif
        return ~(one << d);
    endfunction

    task automatic scan_blank(input string name, input int n0, input int nedges);
        for (int n = n0; n < n0 + nedges; n++) begin
            @(negedge clk);
            chk({name, " an"}, 32'(an), 32'(exp_an(n)));
            chk({name, " seg"}, 32'(seg), 32'h7F);
        end
    endtask

    // Whenever a single digit is lit, its segments must show the expected glyph or blank.
    task automatic disp_check(input string name, input logic [11:0] ec, input logic [3:0] ev, input int cycles);
        int d;
        logic [6:0] es;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            d = -1;
            for (int k = 0; k < DIGITS; k++)
                if (an == ~(4'b0001 << k)) d = k;
            if (d < 0) begin
                chk({name, " an dark"}, 32'(an), 32'hF);
            end else begin
                es = ev[d] ? glyph(int'(ec[d*CODE_W +: CODE_W])) : 7'b1111111;
                chk({name, " seg"}, 32'(seg), 32'(es));
            end
        end
    endtask

    initial begin
        vt[0] = '{32'hFF00_9001, 12'hE38, 4'b1011};
        vt[1] = '{32'h0804_0201, 12'h688, 4'b1111};
        vt[2] = '{32'h8040_2010, 12'hFAC, 4'b1111};
        vt[3] = '{32'h0000_0000, 12'h000, 4'b0000};
        vt[4] = '{32'h8103_00FF, 12'hE47, 4'b1101};

        // Reset and idle scan
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst an", 32'(an), 32'hF);
        chk("rst seg", 32'(seg), 32'h7F);
        chk("rst code", 32'(code), 32'h0);
        chk("rst valid", 32'(valid), 32'h0);
        rst_n = 1'b1;
        scan_blank("idle", 1, 16);

        // Encode vectors
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            x = vt[i].x;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            chk($sformatf("enc%0d code", i), 32'(code), 32'(vt[i].code));
            chk($sformatf("enc%0d valid", i), 32'(valid), 32'(vt[i].valid));
            disp_check($sformatf("enc%0d", i), vt[i].code, vt[i].valid, 16);
        end

        // Hold across two frames with x changing and load low
        x = 32'h1234_5678;
        disp_check("hold", vt[4].code, vt[4].valid, 16);
        x = 32'h0000_0001;
        disp_check("hold", vt[4].code, vt[4].valid, 16);
        chk("hold code", 32'(code), 32'(vt[4].code));
        chk("hold valid", 32'(valid), 32'(vt[4].valid));

        // Load on the edge that ends slot 0 (cnt=3, idx=0 is edge 4 after release)
        @(negedge clk);
        x = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        x = 32'h0000_0400;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("bnd code", 32'(code), 32'h010);
        chk("bnd valid", 32'(valid), 32'h2);
        chk("bnd an4", 32'(an), 32'(exp_an(4)));
        @(negedge clk);
        chk("bnd an5", 32'(an), 32'hD);
        chk("bnd seg5", 32'(seg), 32'(7'b0010010));

        // Async reset while digit 2 is being scanned
        repeat (4) @(negedge clk);
        chk("mid an9", 32'(an), 32'hB);
        #1 rst_n = 1'b0;
        #1;
        chk("mid an", 32'(an), 32'hF);
        chk("mid seg", 32'(seg), 32'h7F);
        chk("mid code", 32'(code), 32'h0);
        chk("mid valid", 32'(valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        scan_blank("resume", 1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
